timer_a0: RTL and testbench
===========================

# timer_a0

Memory-mapped 16-bit timer peripheral that hangs off the system bus beside RAM, FRAM and the IVT inside the memory map, decoding its own address window from MAB. Provides stop/up/continuous/up-down counting from MCLK with a power-of-two prescaler and one compare register (CCR0). Raises two level interrupt requests (CCR0 and overflow) toward the CPU interrupt logic.

## Interface
- BASE, 16'h0340, word-aligned base address of the 0x20-byte register window
- MCLK  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- MAB  in  16  memory address bus
- MDBwrite  in  16  write data from CPU
- MW  in  1  memory write strobe, sampled on MCLK rising edge
- BW  in  1  byte access (1) / word access (0)
- INTACK_CCR0  in  1  one-cycle pulse from CPU when CCR0 vector is taken
- MDBread  out  16  read data; 16'hzzzz unless MAB selects a mapped register
- IRQ_CCR0  out  1  CCIE & CCIFG
- IRQ_TA  out  1  TAIE & TAIFG

## Operation
- Register map (word offsets from BASE): +0x00 TA0CTL, +0x02 TA0CCTL0, +0x10 TA0R, +0x12 TA0CCR0. Other offsets in window and all addresses outside it: MDBread = 16'hzzzz, writes ignored.
- TA0CTL: [7:6] ID (divide 1/2/4/8), [5:4] MC (00 stop, 01 up, 10 continuous, 11 up/down), [2] TACLR (write-only, reads 0), [1] TAIE, [0] TAIFG; other bits read 0.
- TA0CCTL0: [4] CCIE, [0] CCIFG; other bits read 0.
- Word write (BW=0): MDBwrite loads whole register. Byte write (BW=1): MDBwrite[7:0] loads low byte if MAB[0]=0, high byte if MAB[0]=1; other byte unchanged.
- Reads: word read returns register; byte read returns selected byte in [7:0], [15:8]=0.
- Prescaler: 3-bit counter; tick asserted when counter reaches 2^ID−1, then counter wraps to 0. ID=0 → tick every MCLK.
- On tick, by MC:
  - stop: TA0R holds.
  - up: if TA0R ≥ TA0CCR0 → TA0R=0, set TAIFG; else TA0R+1; set CCIFG when TA0R becomes TA0CCR0.
  - continuous: TA0R+1 mod 2^16; set TAIFG on FFFF→0000; set CCIFG when TA0R becomes TA0CCR0.
  - up/down: dir flag (reset = up). Up: TA0R+1, on reaching CCR0 set CCIFG, dir→down. Down: TA0R−1, on reaching 0 set TAIFG, dir→up.
  - TA0CCR0 = 0 in up or up/down: TA0R forced and held at 0, no flags set.
- TACLR write of 1: TA0R, prescaler counter and dir cleared same edge; other TA0CTL fields take written value.
- Write to TA0R loads value; no tick applied that cycle. Write to TA0CCR0 affects comparison from next cycle.
- CCIFG cleared by software write of 0 or INTACK_CCR0. TAIFG cleared only by software.
- Simultaneous hardware flag set and software clear/INTACK on same edge: set wins.

## Timing
- Reset: all registers 0, prescaler 0, dir up, IRQ_CCR0=0, IRQ_TA=0, MDBread = 16'hzzzz unless address selected (then reads 0).
- Reads combinational from MAB, zero latency; value reflects register state before the current edge.
- Writes commit on the MCLK edge where MW=1; readable the following cycle.
- Flag sets and IRQ outputs registered: IRQ rises the cycle after the edge that updates TA0R to the trigger value.
- Changing ID mid-count: prescaler counter not cleared; new divide compared immediately (tick when counter == 2^ID−1, or wrap at 7).
- rst mid-count: overrides every write and tick on that edge.

## Test plan
- Reset, read BASE+0x00/0x02/0x10/0x12 → all 0000; read BASE+0x04 and 0x0200 from this block → zzzz.
- CCR0=4, CTL=0x0010 (up, ID=0) → TA0R sequence 1,2,3,4,0,1; CCIFG set when TA0R=4, TAIFG set at 4→0; with CCIE=1, IRQ_CCR0 high next cycle, INTACK_CCR0 pulse clears it.
- CTL=0x0060 (continuous, ID=/2... ID=01), TA0R preloaded 0xFFFE → TA0R increments every 2 MCLKs, wraps to 0000, TAIFG=1; IRQ_TA only when TAIE=1.
- Up/down, CCR0=3 → TA0R 1,2,3,2,1,0,1; CCIFG at 3, TAIFG at 0.
- Byte write 0xAB to BASE+0x13 with CCR0=0x1234 → CCR0=0xAB34; byte read of BASE+0x13 → 0x00AB.
- CCIFG software clear on same edge hardware sets it → CCIFG reads 1; TACLR mid-count → TA0R=0 next cycle, MC preserved from written value.

Source files
------------

// File: rtl/timer_a0.sv
// timer_a0: memory-mapped 16-bit timer with a power-of-two prescaler, one
// compare register (CCR0) and stop/up/continuous/up-down counting modes.
// Raises level interrupt requests for the CCR0 match and for overflow.
module timer_a0 #(
  parameter logic [15:0] BASE = 16'h0340
) (
  input  logic        MCLK,
  input  logic        rst,
  input  logic [15:0] MAB,
  input  logic [15:0] MDBwrite,
  input  logic        MW,
  input  logic        BW,
  input  logic        INTACK_CCR0,
  output logic [15:0] MDBread,
  output logic        IRQ_CCR0,
  output logic        IRQ_TA
);

  typedef enum logic [1:0] {
    MC_STOP   = 2'b00,
    MC_UP     = 2'b01,
    MC_CONT   = 2'b10,
    MC_UPDOWN = 2'b11
  } mc_t;

  // Register state
  logic [1:0]  id;
  mc_t         mc;
  logic        taie;
  logic        taifg;
  logic        ccie;
  logic        ccifg;
  logic [15:0] tar;
  logic [15:0] ccr0;
  logic [2:0]  presc;
  logic        dir_down;

  // Address decode: the window is 0x20 bytes, registers sit on word offsets
  logic in_win;
  logic sel_ctl, sel_cctl, sel_tar, sel_ccr;
  logic wr_ctl, wr_cctl, wr_tar, wr_ccr;

  assign in_win   = (MAB[15:5] == BASE[15:5]);
  assign sel_ctl  = in_win && (MAB[4:1] == 4'h0);
  assign sel_cctl = in_win && (MAB[4:1] == 4'h1);
  assign sel_tar  = in_win && (MAB[4:1] == 4'h8);
  assign sel_ccr  = in_win && (MAB[4:1] == 4'h9);

  assign wr_ctl  = MW && sel_ctl;
  assign wr_cctl = MW && sel_cctl;
  assign wr_tar  = MW && sel_tar;
  assign wr_ccr  = MW && sel_ccr;

  // Software-visible register images (TACLR always reads back as 0)
  logic [15:0] ctl_rd, cctl_rd;
  assign ctl_rd  = {8'h00, id, mc, 1'b0, 1'b0, taie, taifg};
  assign cctl_rd = {11'd0, ccie, 3'd0, ccifg};

  // Byte writes replace only the addressed byte of the current value
  function automatic logic [15:0] merge(input logic [15:0] cur,
                                        input logic [15:0] wdata,
                                        input logic        bw,
                                        input logic        hi);
    if (!bw)     return wdata;
    else if (hi) return {wdata[7:0], cur[7:0]};
    else         return {cur[15:8], wdata[7:0]};
  endfunction

  logic [15:0] ctl_wd, cctl_wd, tar_wd, ccr_wd;
  assign ctl_wd  = merge(ctl_rd,  MDBwrite, BW, MAB[0]);
  assign cctl_wd = merge(cctl_rd, MDBwrite, BW, MAB[0]);
  assign tar_wd  = merge(tar,     MDBwrite, BW, MAB[0]);
  assign ccr_wd  = merge(ccr0,    MDBwrite, BW, MAB[0]);

  // Read mux: combinational from MAB, high impedance outside mapped registers
  logic        hit;
  logic [15:0] rd_word;
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    hit     = 1'b0;
    rd_word = 16'h0000;
    if (sel_ctl)  begin hit = 1'b1; rd_word = ctl_rd;  end
    if (sel_cctl) begin hit = 1'b1; rd_word = cctl_rd; end
    if (sel_tar)  begin hit = 1'b1; rd_word = tar;     end
    if (sel_ccr)  begin hit = 1'b1; rd_word = ccr0;    end
  end

  assign MDBread = !hit ? 16'hzzzz :
                   !BW  ? rd_word  :
                   MAB[0] ? {8'h00, rd_word[15:8]} : {8'h00, rd_word[7:0]};

  // Prescaler: ticks when the counter hits 2^ID-1; held while stopped
  logic [2:0] presc_max;
  logic [2:0] presc_nxt;
  logic       tick;
  always_comb begin
    presc_nxt = presc;
    tick      = 1'b0;
    case (id)
      2'd0:    presc_max = 3'd0;
      2'd1:    presc_max = 3'd1;
      2'd2:    presc_max = 3'd3;
      default: presc_max = 3'd7;
    endcase
    if (mc != MC_STOP) begin
      if (presc == presc_max) begin
        tick      = 1'b1;
        presc_nxt = 3'd0;
      end else begin
        presc_nxt = presc + 3'd1;
      end
    end
  end

  // Counter next state and hardware flag events; a TA0R write suppresses the tick
  logic [15:0] tar_inc, tar_dec, tar_cnt;
  logic        dir_cnt, hw_cc, hw_ta;
  assign tar_inc = tar + 16'd1;
  assign tar_dec = tar - 16'd1;
  always_comb begin
    tar_cnt = tar;
    dir_cnt = dir_down;
    hw_cc   = 1'b0;
    hw_ta   = 1'b0;
    if (tick && !wr_tar) begin
      case (mc)
        MC_UP: begin
          if (ccr0 == 16'd0) begin
            tar_cnt = 16'd0;
          end else if (tar >= ccr0) begin
            tar_cnt = 16'd0;
            hw_ta   = 1'b1;
          end else begin
            tar_cnt = tar_inc;
            hw_cc   = (tar_inc == ccr0);
          end
        end
        MC_CONT: begin
          tar_cnt = tar_inc;
          hw_ta   = (tar == 16'hFFFF);
          hw_cc   = (tar_inc == ccr0);
        end
        MC_UPDOWN: begin
          if (ccr0 == 16'd0) begin
            tar_cnt = 16'd0;
            dir_cnt = 1'b0;
          end else if (!dir_down) begin
            if (tar >= ccr0) begin
              tar_cnt = tar_dec;
              dir_cnt = 1'b1;
            end else begin
              tar_cnt = tar_inc;
              if (tar_inc == ccr0) begin
                hw_cc   = 1'b1;
                dir_cnt = 1'b1;
              end
            end
          end else begin
            if (tar == 16'd0) begin
              tar_cnt = tar_inc;
              dir_cnt = 1'b0;
            end else begin
              tar_cnt = tar_dec;
              if (tar_dec == 16'd0) begin
                hw_ta   = 1'b1;
                dir_cnt = 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State update: reset beats everything, bus writes beat counting, flag sets beat clears
  always_ff @(posedge MCLK) begin
    if (rst) begin
      id       <= 2'd0;
      mc       <= MC_STOP;
      taie     <= 1'b0;
      taifg    <= 1'b0;
      ccie     <= 1'b0;
      ccifg    <= 1'b0;
      tar      <= 16'd0;
      ccr0     <= 16'd0;
      presc    <= 3'd0;
      dir_down <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every term reads pre-edge state;
      // later assignments in this block deliberately override earlier ones.
      presc    <= presc_nxt;
      tar      <= tar_cnt;
      dir_down <= dir_cnt;
      taifg    <= hw_ta | (wr_ctl ? ctl_wd[0] : taifg);
      ccifg    <= hw_cc | (wr_cctl ? cctl_wd[0] : (ccifg & ~INTACK_CCR0));
      if (wr_ctl) begin
        id   <= ctl_wd[7:6];
        mc   <= mc_t'(ctl_wd[5:4]);
        taie <= ctl_wd[1];
        if (ctl_wd[2]) begin
          tar      <= 16'd0;
          presc    <= 3'd0;
          dir_down <= 1'b0;
        end
      end
      if (wr_cctl) ccie <= cctl_wd[4];
      if (wr_tar)  tar  <= tar_wd;
      if (wr_ccr)  ccr0 <= ccr_wd;
    end
  end

  assign IRQ_CCR0 = ccie & ccifg;
  assign IRQ_TA   = taie & taifg;

endmodule

// File: tb/tb_timer_a0.sv
// Self-checking bench for timer_a0: expected observations are queued with the
// stimulus that causes them and compared as the DUT reaches each cycle.
module tb_timer_a0;

  localparam logic [15:0] A_CTL  = 16'h0340;
  localparam logic [15:0] A_CCTL = 16'h0342;
  localparam logic [15:0] A_TAR  = 16'h0350;
  localparam logic [15:0] A_CCR  = 16'h0352;

  localparam int K_BUS = 0;
  localparam int K_IRQ_CCR0 = 1;
  localparam int K_IRQ_TA = 2;

  logic        MCLK = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] MAB = 16'h0000;
  logic [15:0] MDBwrite = 16'h0000;
  logic        MW = 1'b0;
  logic        BW = 1'b0;
  logic        INTACK_CCR0 = 1'b0;
  logic [15:0] MDBread;
  logic        IRQ_CCR0;
  logic        IRQ_TA;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          adv;   // negedges to advance before observing
    int          kind;
    logic [15:0] addr;
    logic        bw;
    logic [15:0] exp;
  } sb_t;

  sb_t sb[$];

  timer_a0 #(.BASE(16'h0340)) dut (
    .MCLK(MCLK),
    .rst(rst),
    .MAB(MAB),
    .MDBwrite(MDBwrite),
    .MW(MW),
    .BW(BW),
    .INTACK_CCR0(INTACK_CCR0),
    .MDBread(MDBread),
    .IRQ_CCR0(IRQ_CCR0),
    .IRQ_TA(IRQ_TA)
  );

  always #10 MCLK = ~MCLK;

  task automatic push(input string name, input int adv, input int kind,
                      input logic [15:0] addr, input logic bw, input logic [15:0] exp);
    sb_t e;
    e.name = name; e.adv = adv; e.kind = kind; e.addr = addr; e.bw = bw; e.exp = exp;
    sb.push_back(e);
  endtask

  // Bus write: called just after a negedge, commits on the following posedge
  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data, input logic bw);
    MAB = addr; MDBwrite = data; BW = bw; MW = 1'b1;
    @(negedge MCLK);
    MW = 1'b0; BW = 1'b0;
  endtask

  // Observe a bus read or an IRQ line without crossing a clock edge
  task automatic sample(input int kind, input logic [15:0] addr, input logic bw,
                        output logic [15:0] got);
    if (kind == K_BUS) begin
      MAB = addr; BW = bw;
      #1 got = MDBread;
      BW = 1'b0;
    end else if (kind == K_IRQ_CCR0) begin
      #1 got = {15'd0, IRQ_CCR0};
    end else begin
      #1 got = {15'd0, IRQ_TA};
    end
  endtask

  task automatic test_reset;
    sb_t e;
    logic [15:0] got;
    rst = 1'b1;
    repeat (2) @(negedge MCLK);
    rst = 1'b0;
    push("rst_ctl",  0, K_BUS, A_CTL,  1'b0, 16'h0000);
    push("rst_cctl", 0, K_BUS, A_CCTL, 1'b0, 16'h0000);
    push("rst_tar",  0, K_BUS, A_TAR,  1'b0, 16'h0000);
    push("rst_ccr",  0, K_BUS, A_CCR,  1'b0, 16'h0000);
    push("rst_unmapped_344", 0, K_BUS, 16'h0344, 1'b0, 16'hzzzz);
    push("rst_outside_200",  0, K_BUS, 16'h0200, 1'b0, 16'hzzzz);
    push("rst_irq_ccr0", 0, K_IRQ_CCR0, 16'h0, 1'b0, 16'h0000);
    push("rst_irq_ta",   0, K_IRQ_TA,   16'h0, 1'b0, 16'h0000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_up;
    sb_t e;
    logic [15:0] got;
    bus_write(A_CCR, 16'd4, 1'b0);
    bus_write(A_CCTL, 16'h0010, 1'b0);
    bus_write(A_CTL, 16'h0010, 1'b0);
    push("up_tar_1", 1, K_BUS, A_TAR, 1'b0, 16'd1);
    push("up_tar_2", 1, K_BUS, A_TAR, 1'b0, 16'd2);
    push("up_tar_3", 1, K_BUS, A_TAR, 1'b0, 16'd3);
    push("up_irq_ccr0_low", 0, K_IRQ_CCR0, 16'h0, 1'b0, 16'h0000);
    push("up_tar_4", 1, K_BUS, A_TAR, 1'b0, 16'd4);
    push("up_ccifg_set", 0, K_BUS, A_CCTL, 1'b0, 16'h0011);
    push("up_irq_ccr0_high", 0, K_IRQ_CCR0, 16'h0, 1'b0, 16'h0001);
    push("up_taifg_clear", 0, K_BUS, A_CTL, 1'b0, 16'h0010);
    push("up_tar_wrap", 1, K_BUS, A_TAR, 1'b0, 16'd0);
    push("up_taifg_set", 0, K_BUS, A_CTL, 1'b0, 16'h0011);
    push("up_irq_ta_masked", 0, K_IRQ_TA, 16'h0, 1'b0, 16'h0000);
    push("up_tar_1b", 1, K_BUS, A_TAR, 1'b0, 16'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    INTACK_CCR0 = 1'b1;
    @(negedge MCLK);
    INTACK_CCR0 = 1'b0;
    sample(K_BUS, A_CCTL, 1'b0, got);
    checks++;
    if (got !== 16'h0010) begin
      errors++;
      $display("FAIL up_intack_cctl: got %h expected %h", got, 16'h0010);
    end
    sample(K_IRQ_CCR0, 16'h0, 1'b0, got);
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL up_intack_irq: got %h expected %h", got, 16'h0000);
    end
    bus_write(A_CTL, 16'h0004, 1'b0);
    bus_write(A_CCTL, 16'h0000, 1'b0);
  endtask

  task automatic test_continuous;
    sb_t e;
    logic [15:0] got;
    bus_write(A_TAR, 16'hFFFE, 1'b0);
    bus_write(A_CTL, 16'h0060, 1'b0);
    push("cont_tar_hold", 1, K_BUS, A_TAR, 1'b0, 16'hFFFE);
    push("cont_tar_ffff", 1, K_BUS, A_TAR, 1'b0, 16'hFFFF);
    push("cont_tar_ffff_hold", 1, K_BUS, A_TAR, 1'b0, 16'hFFFF);
    push("cont_tar_wrap", 1, K_BUS, A_TAR, 1'b0, 16'h0000);
    push("cont_taifg_set", 0, K_BUS, A_CTL, 1'b0, 16'h0061);
    push("cont_irq_ta_masked", 0, K_IRQ_TA, 16'h0, 1'b0, 16'h0000);
    push("cont_tar_0_hold", 1, K_BUS, A_TAR, 1'b0, 16'h0000);
    push("cont_tar_1", 1, K_BUS, A_TAR, 1'b0, 16'h0001);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    bus_write(A_CTL, 16'h0063, 1'b0);
    sample(K_IRQ_TA, 16'h0, 1'b0, got);
    checks++;
    if (got !== 16'h0001) begin
      errors++;
      $display("FAIL cont_irq_ta_enabled: got %h expected %h", got, 16'h0001);
    end
    bus_write(A_CTL, 16'h0062, 1'b0);
    sample(K_IRQ_TA, 16'h0, 1'b0, got);
    checks++;
    if (got !== 16'h0000) begin
      errors++;
      $display("FAIL cont_irq_ta_cleared: got %h expected %h", got, 16'h0000);
    end
    bus_write(A_CTL, 16'h0004, 1'b0);
    bus_write(A_CCTL, 16'h0000, 1'b0);
  endtask

  task automatic test_updown;
    sb_t e;
    logic [15:0] got;
    bus_write(A_CCR, 16'd3, 1'b0);
    bus_write(A_CTL, 16'h0030, 1'b0);
    push("ud_tar_1", 1, K_BUS, A_TAR, 1'b0, 16'd1);
    push("ud_tar_2", 1, K_BUS, A_TAR, 1'b0, 16'd2);
    push("ud_ccifg_clear", 0, K_BUS, A_CCTL, 1'b0, 16'h0000);
    push("ud_tar_3", 1, K_BUS, A_TAR, 1'b0, 16'd3);
    push("ud_ccifg_set", 0, K_BUS, A_CCTL, 1'b0, 16'h0001);
    push("ud_taifg_clear", 0, K_BUS, A_CTL, 1'b0, 16'h0030);
    push("ud_tar_2b", 1, K_BUS, A_TAR, 1'b0, 16'd2);
    push("ud_tar_1b", 1, K_BUS, A_TAR, 1'b0, 16'd1);
    push("ud_tar_0", 1, K_BUS, A_TAR, 1'b0, 16'd0);
    push("ud_taifg_set", 0, K_BUS, A_CTL, 1'b0, 16'h0031);
    push("ud_tar_1c", 1, K_BUS, A_TAR, 1'b0, 16'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    bus_write(A_CTL, 16'h0004, 1'b0);
    bus_write(A_CCTL, 16'h0000, 1'b0);
  endtask

  task automatic test_byte_access;
    sb_t e;
    logic [15:0] got;
    bus_write(A_CCR, 16'h1234, 1'b0);
    bus_write(A_CCR | 16'h0001, 16'hCDAB, 1'b1);
    push("byte_hi_word", 0, K_BUS, A_CCR, 1'b0, 16'hAB34);
    push("byte_hi_read", 0, K_BUS, A_CCR | 16'h0001, 1'b1, 16'h00AB);
    push("byte_lo_read", 0, K_BUS, A_CCR, 1'b1, 16'h0034);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    bus_write(A_CCR, 16'hEF56, 1'b1);
    sample(K_BUS, A_CCR, 1'b0, got);
    checks++;
    if (got !== 16'hAB56) begin
      errors++;
      $display("FAIL byte_lo_word: got %h expected %h", got, 16'hAB56);
    end
  endtask

  task automatic test_set_wins_and_taclr;
    sb_t e;
    logic [15:0] got;
    bus_write(A_CCR, 16'd5, 1'b0);
    bus_write(A_CTL, 16'h0014, 1'b0);
    repeat (4) @(negedge MCLK);
    // Software clear lands on the same edge the counter reaches CCR0
    bus_write(A_CCTL, 16'h0000, 1'b0);
    push("setwins_tar", 0, K_BUS, A_TAR, 1'b0, 16'd5);
    push("setwins_ccifg", 0, K_BUS, A_CCTL, 1'b0, 16'h0001);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
    repeat (2) @(negedge MCLK);
    bus_write(A_CTL, 16'h0024, 1'b0);
    push("taclr_tar", 0, K_BUS, A_TAR, 1'b0, 16'd0);
    push("taclr_ctl", 0, K_BUS, A_CTL, 1'b0, 16'h0020);
    push("taclr_tar_1", 1, K_BUS, A_TAR, 1'b0, 16'd1);
    push("taclr_tar_2", 1, K_BUS, A_TAR, 1'b0, 16'd2);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  task automatic test_reset_midcount;
    sb_t e;
    logic [15:0] got;
    bus_write(A_CCTL, 16'h0011, 1'b0);
    // Reset coincides with a CCR0 write while the counter runs
    rst = 1'b1; MAB = A_CCR; MDBwrite = 16'hFFFF; MW = 1'b1;
    @(negedge MCLK);
    rst = 1'b0; MW = 1'b0;
    push("mrst_ctl",  0, K_BUS, A_CTL,  1'b0, 16'h0000);
    push("mrst_cctl", 0, K_BUS, A_CCTL, 1'b0, 16'h0000);
    push("mrst_tar",  0, K_BUS, A_TAR,  1'b0, 16'h0000);
    push("mrst_ccr",  0, K_BUS, A_CCR,  1'b0, 16'h0000);
    push("mrst_irq_ccr0", 0, K_IRQ_CCR0, 16'h0, 1'b0, 16'h0000);
    push("mrst_tar_hold", 1, K_BUS, A_TAR, 1'b0, 16'h0000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      repeat (e.adv) @(negedge MCLK);
      sample(e.kind, e.addr, e.bw, got);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_continuous();
    test_updown();
    test_byte_access();
    test_set_wins_and_taclr();
    test_reset_midcount();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
